// File: rtl/mem_axil_master.sv
// mem_axil_master
//   Bridges the PicoRV32 native memory interface (mem_valid/mem_ready) to an
//   AXI4-Lite master port. One transaction (read or write) is outstanding at
//   a time. AW and W are tracked independently, so any AW/W ordering is
//   accepted, including slaves with combinational ready/valid.
//
// Parameters
//   ADDR_W          AXI address width (mem_addr[ADDR_W-1:0] is forwarded)
//   TIMEOUT_CYCLES  watchdog limit in clk cycles (AXIL_TIMEOUT_EN only)
//
// Optional feature
//   `define AXIL_TIMEOUT_EN : a watchdog aborts a WRITE/READ that has not
//   completed after TIMEOUT_CYCLES cycles. Aborted transactions report
//   bus_err=1, and aborted reads return 32'hDEADBEEF.
//
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   mem_*               PicoRV32 native request / completion
//   bus_err             error flag, pulses together with mem_ready
//   m_axi_aw*/w*/b*     AXI4-Lite write channels
//   m_axi_ar*/r*        AXI4-Lite read channels
//   All outputs come straight from flops.
module mem_axil_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              bus_err,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        prot_q, prot_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       rdata_q, rdata_d;

`ifdef AXIL_TIMEOUT_EN
  logic [31:0] count_q, count_d;
  logic        expired;
  assign expired = (count_q == 32'(TIMEOUT_CYCLES - 1));
`endif

  // mem_ready/bus_err are set on the edge that enters DONE and fall back to 0
  // by default, which yields the single-cycle completion pulse.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    prot_d      = prot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    mem_ready_d = 1'b0;
    bus_err_d   = 1'b0;
    rdata_d     = rdata_q;
`ifdef AXIL_TIMEOUT_EN
    count_d     = (state_q == S_IDLE) ? '0 : count_q + 32'd1;
`endif

    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr[ADDR_W-1:0];
          prot_d  = {mem_instr, 2'b00};
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          if (mem_wstrb != 4'h0) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
          end else begin
            state_d   = S_READ;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end

      S_WRITE: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (m_axi_bvalid && bready_q) begin
          state_d     = S_DONE;
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          bus_err_d   = (m_axi_bresp != 2'b00);
        end
`ifdef AXIL_TIMEOUT_EN
        else if (expired) begin
          state_d     = S_DONE;
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          bus_err_d   = 1'b1;
        end
`endif
      end

      S_READ: begin
        if (arvalid_q && m_axi_arready) arvalid_d = 1'b0;
        // rready is already high in the AR cycle, so a combinational R
        // response is taken in that same cycle.
        if (m_axi_rvalid && rready_q) begin
          state_d     = S_DONE;
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          mem_ready_d = 1'b1;
          bus_err_d   = (m_axi_rresp != 2'b00);
          rdata_d     = m_axi_rdata;
        end
`ifdef AXIL_TIMEOUT_EN
        else if (expired) begin
          state_d     = S_DONE;
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          mem_ready_d = 1'b1;
          bus_err_d   = 1'b1;
          rdata_d     = 32'hDEAD_BEEF;
        end
`endif
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      prot_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      rdata_q     <= '0;
`ifdef AXIL_TIMEOUT_EN
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      prot_q      <= prot_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      rdata_q     <= rdata_d;
`ifdef AXIL_TIMEOUT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign mem_ready     = mem_ready_q;
  assign mem_rdata     = rdata_q;
  assign bus_err       = bus_err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = prot_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = prot_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_mem_axil_master.sv
// Testbench for mem_axil_master: a configurable AXI4-Lite slave model plus a
// scoreboard of expected {rdata, bus_err} completions.
module tb_mem_axil_master;
`ifdef AXIL_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 1024;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, bus_err;
  logic [31:0] mem_rdata;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = '0;

  always #5 clk = ~clk;

  mem_axil_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_err(bus_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] model_rdata = '0;

  // Slave configuration
  int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
  bit          aw_stuck, ar_stuck;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;

  // Slave state and observations
  bit          aw_done, w_done, ar_done;
  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs, awv_cyc, wv_cyc, arv_cyc;
  logic [31:0] got_awaddr, got_wdata, got_araddr;
  logic [3:0]  got_wstrb;
  logic [2:0]  got_awprot, got_arprot;

  // Slave reacts on the falling edge: DUT outputs are stable there, and the
  // readies/valids it drives are what the DUT sees at the next rising edge,
  // so a handshake is counted when it is set up here.
  always @(negedge clk) begin
    if (!resetn) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      aw_done = 0; w_done = 0; ar_done = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      m_axi_bvalid = 1'b0;
      if (aw_done && w_done) begin
        if (b_wait >= b_lat) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = bresp_cfg;
          if (m_axi_bready) begin
            b_hs++; aw_done = 0; w_done = 0; b_wait = 0;
          end
        end else b_wait++;
      end
      m_axi_awready = 1'b0;
      if (m_axi_awvalid) begin
        awv_cyc++;
        if (!aw_done && !aw_stuck) begin
          if (aw_wait >= aw_lat) begin
            m_axi_awready = 1'b1; aw_done = 1; aw_wait = 0; aw_hs++;
            got_awaddr = m_axi_awaddr; got_awprot = m_axi_awprot;
          end else aw_wait++;
        end
      end
      m_axi_wready = 1'b0;
      if (m_axi_wvalid) begin
        wv_cyc++;
        if (!w_done) begin
          if (w_wait >= w_lat) begin
            m_axi_wready = 1'b1; w_done = 1; w_wait = 0; w_hs++;
            got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb;
          end else w_wait++;
        end
      end
      m_axi_arready = 1'b0;
      if (m_axi_arvalid) begin
        arv_cyc++;
        if (!ar_done && !ar_stuck) begin
          if (ar_wait >= ar_lat) begin
            m_axi_arready = 1'b1; ar_done = 1; ar_wait = 0; ar_hs++;
            got_araddr = m_axi_araddr; got_arprot = m_axi_arprot;
          end else ar_wait++;
        end
      end
      m_axi_rvalid = 1'b0;
      if (ar_done) begin
        if (r_wait >= r_lat) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg;
          if (m_axi_rready) begin
            r_hs++; ar_done = 0; r_wait = 0;
          end
        end else r_wait++;
      end
    end
  end

  task automatic cfg_default();
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
    aw_stuck = 0; ar_stuck = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = '0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    awv_cyc = 0; wv_cyc = 0; arv_cyc = 0;
  endtask

  // Drives one request, holds mem_valid until mem_ready, and reports what
  // was observed; callers do the comparisons.
  task automatic issue_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr, input int budget,
                           output bit seen, output int lat, output logic [31:0] rd,
                           output logic err, output logic next_ready);
    @(posedge clk); #2;
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_instr = instr;
    mem_valid = 1'b1;
    seen = 0; lat = 0; rd = '0; err = 1'b0;
    while (!seen && lat < budget) begin
      @(posedge clk); #2;
      lat++;
      if (mem_ready) begin
        seen = 1; rd = mem_rdata; err = bus_err;
      end
    end
    mem_valid = 1'b0;
    @(posedge clk); #2;
    next_ready = mem_ready;
  endtask

  task automatic test_reset();
    resetn = 1'b0; mem_valid = 1'b1; mem_instr = 1'b1;
    mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      bad++; $display("FAIL reset_valids: got %b want 00000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    total++;
    if ({mem_ready, bus_err} !== 2'b00) begin
      bad++; $display("FAIL reset_ready_err: got %b want 00", {mem_ready, bus_err});
    end
    total++;
    if (mem_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 00000000", mem_rdata);
    end
    total++;
    if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb, m_axi_awprot, m_axi_arprot} !== '0) begin
      bad++; $display("FAIL reset_payload: awaddr=%h wdata=%h wstrb=%h awprot=%b want all zero",
        m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_awprot);
    end
    mem_valid = 1'b0;
    resetn = 1'b1;
    model_rdata = '0;
  endtask

  task automatic test_write_basic();
    bit seen; int lat; logic [31:0] rd; logic err, nr; exp_t e;
    cfg_default(); b_lat = 1;
    exp_q.push_back('{rdata: model_rdata, err: 1'b0});
    issue_req(32'h0, 32'h0000_0041, 4'hF, 1'b0, 64, seen, lat, rd, err, nr);
    e = exp_q.pop_front();
    total++;
    if (!seen) begin bad++; $display("FAIL wr_basic_done: no mem_ready within 64 cycles"); end
    total++;
    if ({rd, err} !== {e.rdata, e.err}) begin
      bad++; $display("FAIL wr_basic_resp: got rdata=%h err=%b want rdata=%h err=%b", rd, err, e.rdata, e.err);
    end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL wr_basic_latency: got %0d want 4", lat); end
    total++;
    if (nr !== 1'b0) begin bad++; $display("FAIL wr_basic_pulse: mem_ready still %b, want 0", nr); end
    total++;
    if ({aw_hs, w_hs, b_hs} !== {32'd1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL wr_basic_hs: aw=%0d w=%0d b=%0d want 1 1 1", aw_hs, w_hs, b_hs);
    end
    total++;
    if ({got_awaddr, got_wdata, got_wstrb, got_awprot} !== {32'h0, 32'h41, 4'hF, 3'b000}) begin
      bad++; $display("FAIL wr_basic_payload: awaddr=%h wdata=%h wstrb=%h prot=%b want 0 41 f 000",
        got_awaddr, got_wdata, got_wstrb, got_awprot);
    end
  endtask

  task automatic test_write_wdelay();
    bit seen; int lat; logic [31:0] rd; logic err, nr; exp_t e;
    cfg_default(); w_lat = 5;
    exp_q.push_back('{rdata: model_rdata, err: 1'b0});
    issue_req(32'h0000_0010, 32'hCAFE_0001, 4'h5, 1'b0, 64, seen, lat, rd, err, nr);
    e = exp_q.pop_front();
    total++;
    if (!seen || {rd, err} !== {e.rdata, e.err}) begin
      bad++; $display("FAIL wr_wdelay_resp: seen=%0d rdata=%h err=%b want rdata=%h err=%b", seen, rd, err, e.rdata, e.err);
    end
    total++;
    if (awv_cyc !== 1 || wv_cyc !== 6) begin
      bad++; $display("FAIL wr_wdelay_valid_cycles: awvalid=%0d wvalid=%0d want 1 6", awv_cyc, wv_cyc);
    end
    total++;
    if (b_hs !== 1 || nr !== 1'b0) begin
      bad++; $display("FAIL wr_wdelay_single: b_hs=%0d next_ready=%b want 1 0", b_hs, nr);
    end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL wr_wdelay_latency: got %0d want 8", lat); end
  endtask

  task automatic test_read_comb();
    bit seen; int lat; logic [31:0] rd; logic err, nr; exp_t e;
    cfg_default(); rdata_cfg = 32'h0000_0003;
    exp_q.push_back('{rdata: 32'h0000_0003, err: 1'b0});
    model_rdata = 32'h0000_0003;
    issue_req(32'h0000_0008, 32'h0, 4'h0, 1'b1, 64, seen, lat, rd, err, nr);
    e = exp_q.pop_front();
    total++;
    if (!seen || {rd, err} !== {e.rdata, e.err}) begin
      bad++; $display("FAIL rd_comb_resp: seen=%0d rdata=%h err=%b want rdata=%h err=%b", seen, rd, err, e.rdata, e.err);
    end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL rd_comb_latency: got %0d want 2", lat); end
    total++;
    if ({got_araddr, got_arprot, ar_hs, r_hs} !== {32'h8, 3'b100, 32'd1, 32'd1}) begin
      bad++; $display("FAIL rd_comb_ar: araddr=%h arprot=%b ar=%0d r=%0d want 8 100 1 1",
        got_araddr, got_arprot, ar_hs, r_hs);
    end
    total++;
    if (nr !== 1'b0 || arv_cyc !== 1) begin
      bad++; $display("FAIL rd_comb_pulse: next_ready=%b arvalid_cycles=%0d want 0 1", nr, arv_cyc);
    end
  endtask

  task automatic test_read_err();
    bit seen; int lat; logic [31:0] rd; logic err, nr; exp_t e;
    cfg_default(); ar_lat = 1; r_lat = 2; rresp_cfg = 2'b10; rdata_cfg = 32'h1234_5678;
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b1});
    model_rdata = 32'h1234_5678;
    issue_req(32'h0000_0104, 32'h0, 4'h0, 1'b0, 64, seen, lat, rd, err, nr);
    e = exp_q.pop_front();
    total++;
    if (!seen || {rd, err} !== {e.rdata, e.err}) begin
      bad++; $display("FAIL rd_err_resp: seen=%0d rdata=%h err=%b want rdata=%h err=%b", seen, rd, err, e.rdata, e.err);
    end
    total++;
    if (nr !== 1'b0) begin bad++; $display("FAIL rd_err_pulse: bus_err/mem_ready lingered, mem_ready=%b", nr); end
  endtask

  task automatic test_write_err_keeps_rdata();
    bit seen; int lat; logic [31:0] rd; logic err, nr; exp_t e;
    cfg_default(); aw_lat = 3; bresp_cfg = 2'b11;
    exp_q.push_back('{rdata: model_rdata, err: 1'b1});
    issue_req(32'h0000_0200, 32'h5555_AAAA, 4'h3, 1'b0, 64, seen, lat, rd, err, nr);
    e = exp_q.pop_front();
    total++;
    if (!seen || {rd, err} !== {e.rdata, e.err}) begin
      bad++; $display("FAIL wr_err_resp: seen=%0d rdata=%h err=%b want rdata=%h err=%b", seen, rd, err, e.rdata, e.err);
    end
    total++;
    if ({got_awaddr, got_wdata, got_wstrb, awv_cyc, wv_cyc} !== {32'h200, 32'h5555_AAAA, 4'h3, 32'd4, 32'd1}) begin
      bad++; $display("FAIL wr_err_aw_late: awaddr=%h wdata=%h wstrb=%h awv=%0d wv=%0d want 200 5555aaaa 3 4 1",
        got_awaddr, got_wdata, got_wstrb, awv_cyc, wv_cyc);
    end
  endtask

  task automatic test_back_to_back();
    bit seen; int lat; logic [31:0] rd; logic err, nr; exp_t e;
    logic [31:0] addr, data; logic [3:0] strb; logic [1:0] resp;
    for (int i = 0; i < 6; i++) begin
      cfg_default();
      aw_lat = $urandom_range(0, 2); w_lat = $urandom_range(0, 2); b_lat = $urandom_range(0, 2);
      ar_lat = $urandom_range(0, 2); r_lat = $urandom_range(0, 2);
      resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      bresp_cfg = resp; rresp_cfg = resp;
      data = $urandom; rdata_cfg = data;
      addr = {$urandom_range(0, 255), 2'b00};
      strb = (i % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (strb == 4'h0) model_rdata = data;
      exp_q.push_back('{rdata: model_rdata, err: (resp != 2'b00)});
      issue_req(addr, data, strb, 1'b0, 64, seen, lat, rd, err, nr);
      e = exp_q.pop_front();
      total++;
      if (!seen || {rd, err} !== {e.rdata, e.err} || nr !== 1'b0) begin
        bad++; $display("FAIL b2b_%0d: seen=%0d rdata=%h err=%b next_ready=%b want rdata=%h err=%b next_ready=0",
          i, seen, rd, err, nr, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit seen; int lat; int pulses; logic [31:0] rd; logic err, nr; exp_t e;
    cfg_default(); aw_stuck = 1;
    @(posedge clk); #2;
    mem_addr = 32'h0000_0300; mem_wdata = 32'h1111_2222; mem_wstrb = 4'hF; mem_instr = 1'b0;
    mem_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (m_axi_awvalid !== 1'b1) begin bad++; $display("FAIL abort_pending: awvalid=%b want 1", m_axi_awvalid); end
    resetn = 1'b0; mem_valid = 1'b0;
    @(posedge clk); #2;
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, mem_ready} !== 4'b0) begin
      bad++; $display("FAIL abort_dropped: aw=%b w=%b b=%b mem_ready=%b want 0000",
        m_axi_awvalid, m_axi_wvalid, m_axi_bready, mem_ready);
    end
    resetn = 1'b1; aw_stuck = 0; model_rdata = '0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      if (mem_ready) pulses++;
    end
    total++;
    if (pulses !== 0 || mem_rdata !== 32'h0) begin
      bad++; $display("FAIL abort_no_ready: pulses=%0d rdata=%h want 0 00000000", pulses, mem_rdata);
    end
    rdata_cfg = 32'h0BAD_F00D;
    exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    model_rdata = 32'h0BAD_F00D;
    issue_req(32'h0000_0040, 32'h0, 4'h0, 1'b0, 64, seen, lat, rd, err, nr);
    e = exp_q.pop_front();
    total++;
    if (!seen || {rd, err} !== {e.rdata, e.err} || b_hs !== 0) begin
      bad++; $display("FAIL abort_then_read: seen=%0d rdata=%h err=%b b_hs=%0d want rdata=%h err=%b b_hs=0",
        seen, rd, err, b_hs, e.rdata, e.err);
    end
  endtask

`ifdef AXIL_TIMEOUT_EN
  task automatic test_timeout();
    bit seen; int lat; logic [31:0] rd; logic err, nr; exp_t e;
    cfg_default(); ar_stuck = 1;
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b1});
    model_rdata = 32'hDEAD_BEEF;
    issue_req(32'h0000_0500, 32'h0, 4'h0, 1'b0, 40, seen, lat, rd, err, nr);
    e = exp_q.pop_front();
    total++;
    if (!seen || {rd, err} !== {e.rdata, e.err}) begin
      bad++; $display("FAIL timeout_resp: seen=%0d rdata=%h err=%b want rdata=%h err=%b", seen, rd, err, e.rdata, e.err);
    end
    total++;
    if (arv_cyc !== 16 || lat !== 17 || m_axi_arvalid !== 1'b0) begin
      bad++; $display("FAIL timeout_timing: arvalid_cycles=%0d latency=%0d arvalid=%b want 16 17 0",
        arv_cyc, lat, m_axi_arvalid);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    cfg_default();
    test_reset();
    test_write_basic();
    test_write_wdelay();
    test_read_comb();
    test_read_err();
    test_write_err_keeps_rdata();
    test_back_to_back();
    test_reset_abort();
`ifdef AXIL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
